// File: rtl/lc3_pkg.sv
// Shared LC-3 constants: memory-mapped I/O addresses, status-register bit positions and opcodes.
package lc3_pkg;

    localparam logic [15:0] AddrKbsr = 16'hFE00;
    localparam logic [15:0] AddrKbdr = 16'hFE02;
    localparam logic [15:0] AddrDsr  = 16'hFE04;
    localparam logic [15:0] AddrDdr  = 16'hFE06;
    localparam logic [15:0] AddrMcr  = 16'hFFFE;

    localparam int unsigned KbsrReadyBit = 15;
    localparam int unsigned KbsrIeBit    = 14;
    localparam int unsigned DsrReadyBit  = 15;
    localparam int unsigned McrRunBit    = 15;

    localparam logic [15:0] McrReset = 16'h8000;

    typedef enum logic [3:0] {
        OpBr   = 4'h0,
        OpAdd  = 4'h1,
        OpLd   = 4'h2,
        OpSt   = 4'h3,
        OpJsr  = 4'h4,
        OpAnd  = 4'h5,
        OpLdr  = 4'h6,
        OpStr  = 4'h7,
        OpRti  = 4'h8,
        OpNot  = 4'h9,
        OpLdi  = 4'hA,
        OpSti  = 4'hB,
        OpJmp  = 4'hC,
        OpRes  = 4'hD,
        OpLea  = 4'hE,
        OpTrap = 4'hF
    } opcode_t;

endpackage

// File: rtl/lc3_console_regs.sv
// Keyboard/display console registers (KBSR, KBDR, DSR, DDR) with their valid/ready handshakes.
module lc3_console_regs
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        write_en,
    input  logic [15:0] address,
    input  logic        wr_ie,
    input  logic [7:0]  wr_char,
    output logic [15:0] rdata,
    output logic        hit,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_char,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_char,
    input  logic        disp_ready
);

    logic       kbd_full_q, ie_q;
    logic [7:0] kbd_data_q;
    logic       dsr_ready_q, disp_valid_q;
    logic [7:0] disp_char_q;
    logic       prev_valid_q, prev_kbdr_q;

    logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, kbdr_first;

    assign sel_kbsr = (address == AddrKbsr);
    assign sel_kbdr = (address == AddrKbdr);
    assign sel_dsr  = (address == AddrDsr);
    assign sel_ddr  = (address == AddrDdr);

    // Only the first cycle of a KBDR access consumes the key; a held address must not re-clear.
    assign kbdr_first = sel_kbdr && !(prev_valid_q && prev_kbdr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_full_q   <= 1'b0;
            ie_q         <= 1'b0;
            kbd_data_q   <= 8'h00;
            dsr_ready_q  <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_char_q  <= 8'h00;
            prev_valid_q <= 1'b0;
            prev_kbdr_q  <= 1'b0;
        end else begin
            prev_valid_q <= 1'b1;
            prev_kbdr_q  <= sel_kbdr;
            if (write_en && sel_kbsr) begin
                ie_q <= wr_ie;
            end
            if (kbd_valid && !kbd_full_q) begin
                kbd_data_q <= kbd_char;
                kbd_full_q <= 1'b1;
            end else if (kbdr_first) begin
                kbd_full_q <= 1'b0;
            end
            // dsr_ready_q and disp_valid_q are never both set, so these arms cannot collide.
            if (write_en && sel_ddr && dsr_ready_q) begin
                disp_char_q  <= wr_char;
                dsr_ready_q  <= 1'b0;
                disp_valid_q <= 1'b1;
            end else if (disp_valid_q && disp_ready) begin
                disp_valid_q <= 1'b0;
                dsr_ready_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = 16'h0000;
        hit   = sel_kbsr || sel_kbdr || sel_dsr || sel_ddr;
        if (sel_kbsr) begin
            rdata[KbsrReadyBit] = kbd_full_q;
            rdata[KbsrIeBit]    = ie_q;
        end else if (sel_kbdr) begin
            rdata[7:0] = kbd_data_q;
        end else if (sel_dsr) begin
            rdata[DsrReadyBit] = dsr_ready_q;
        end else if (sel_ddr) begin
            rdata[7:0] = disp_char_q;
        end
    end

    assign kbd_ready  = !kbd_full_q;
    assign disp_valid = disp_valid_q;
    assign disp_char  = disp_char_q;

endmodule

// File: rtl/lc3_memory_io.sv
// LC-3 memory system: RAM at address 0, console MMIO and optional machine control register.
// Define LC3_MCR_EN to map MCR at 16'hFFFE and drive run from MCR[15]; otherwise run is tied high.
module lc3_memory_io
    import lc3_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 4096,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        writeEnable,
    input  logic [15:0] address,
    input  logic [15:0] dataToMemory,
    output logic [15:0] dataFromMemory,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_char,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_char,
    input  logic        disp_ready,
    output logic        run
);

    localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [15:0] mem [RAM_WORDS];
    logic        ram_hit;
    logic [15:0] con_rdata;
    logic        con_hit;

    assign ram_hit = 32'(address) < RAM_WORDS;

    // RAM is deliberately left out of reset so program images survive a CPU reset.
    always_ff @(posedge clk) begin
        if (writeEnable && ram_hit) begin
            mem[address[AW-1:0]] <= dataToMemory;
        end
    end

    lc3_console_regs u_console (
        .clk        (clk),
        .reset      (reset),
        .write_en   (writeEnable),
        .address    (address),
        .wr_ie      (dataToMemory[KbsrIeBit]),
        .wr_char    (dataToMemory[7:0]),
        .rdata      (con_rdata),
        .hit        (con_hit),
        .kbd_valid  (kbd_valid),
        .kbd_char   (kbd_char),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_char  (disp_char),
        .disp_ready (disp_ready)
    );

`ifdef LC3_MCR_EN
    logic [15:0] mcr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcr_q <= McrReset;
        end else if (writeEnable && (address == AddrMcr)) begin
            mcr_q <= dataToMemory;
        end
    end

    assign run = mcr_q[McrRunBit];
`else
    assign run = 1'b1;
`endif

    always_comb begin
        dataFromMemory = 16'h0000;
        if (ram_hit) begin
            dataFromMemory = mem[address[AW-1:0]];
        end else if (con_hit) begin
            dataFromMemory = con_rdata;
`ifdef LC3_MCR_EN
        end else if (address == AddrMcr) begin
            dataFromMemory = mcr_q;
`endif
        end
    end

endmodule

// File: tb/tb_lc3_memory_io.sv
// Table-driven self-checking bench for lc3_memory_io with a per-cycle expectation scoreboard.
module tb_lc3_memory_io;

`ifdef LC3_MCR_EN
    localparam logic McrEn = 1'b1;
`else
    localparam logic McrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        writeEnable;
    logic [15:0] address;
    logic [15:0] dataToMemory;
    logic [15:0] dataFromMemory;
    logic        kbd_valid;
    logic [7:0]  kbd_char;
    logic        kbd_ready;
    logic        disp_valid;
    logic [7:0]  disp_char;
    logic        disp_ready;
    logic        run;

    always #5 clk = ~clk;

    lc3_memory_io dut (
        .clk            (clk),
        .reset          (reset),
        .writeEnable    (writeEnable),
        .address        (address),
        .dataToMemory   (dataToMemory),
        .dataFromMemory (dataFromMemory),
        .kbd_valid      (kbd_valid),
        .kbd_char       (kbd_char),
        .kbd_ready      (kbd_ready),
        .disp_valid     (disp_valid),
        .disp_char      (disp_char),
        .disp_ready     (disp_ready),
        .run            (run)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        kv;
        logic [7:0]  kc;
        logic        dr;
        logic        cmp_rd;
        logic [15:0] rd;
        logic        kr;
        logic        dv;
        logic [7:0]  dc;
        logic        run;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic rst, input logic we, input logic [15:0] addr,
                                input logic [15:0] wd, input logic kv, input logic [7:0] kc,
                                input logic dr, input logic cmp_rd, input logic [15:0] rd,
                                input logic kr, input logic dv, input logic [7:0] dc,
                                input logic run_e);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.wd = wd; v.kv = kv; v.kc = kc; v.dr = dr;
        v.cmp_rd = cmp_rd; v.rd = rd; v.kr = kr; v.dv = dv; v.dc = dc; v.run = run_e;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, then compare outputs well before the next rising edge.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        reset        = v.rst;
        writeEnable  = v.we;
        address      = v.addr;
        dataToMemory = v.wd;
        kbd_valid    = v.kv;
        kbd_char     = v.kc;
        disp_ready   = v.dr;
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        if (e.cmp_rd) check($sformatf("rd[%0d]", idx), dataFromMemory, e.rd);
        check($sformatf("kbd_ready[%0d]", idx), 16'(kbd_ready), 16'(e.kr));
        check($sformatf("disp_valid[%0d]", idx), 16'(disp_valid), 16'(e.dv));
        check($sformatf("disp_char[%0d]", idx), 16'(disp_char), 16'(e.dc));
        check($sformatf("run[%0d]", idx), 16'(run), 16'(e.run));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // rst we addr wd kv kc dr | cmp rd kr dv dc run
        tbl.push_back(mk(0, 0, 16'hFE00, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 1, 16'h8000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 16'h0010, 16'h1234, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'h0010, 16'h0000, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 16'h0011, 16'hABCD, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'h0011, 16'h0000, 0, 8'h00, 0, 1, 16'hABCD, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'h0010, 16'h0000, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 16'h0000, 16'h2222, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 16'h0FFF, 16'h5A5A, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'h0FFF, 16'h0000, 0, 8'h00, 0, 1, 16'h5A5A, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 16'h1000, 16'h1111, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'h1000, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0, 1, 16'h2222, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFFFF, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 16'hFFF0, 16'hFFFF, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFFF0, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        // KBSR interrupt-enable write, then keyboard accept / consume
        tbl.push_back(mk(0, 1, 16'hFE00, 16'hFFFF, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE00, 16'h0000, 0, 8'h00, 0, 1, 16'h4000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 16'hFE00, 16'h0000, 1, 8'h41, 0, 1, 16'h4000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE00, 16'h0000, 1, 8'h42, 0, 1, 16'h8000, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE02, 16'h0000, 1, 8'h42, 0, 1, 16'h0041, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE00, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'h0010, 16'h0000, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 1));
        // KBDR held five cycles, new key accepted in the third
        tbl.push_back(mk(0, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 1, 16'h0041, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 1, 16'h0041, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE02, 16'h0000, 1, 8'h43, 0, 1, 16'h0041, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 1, 16'h0043, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 1, 16'h0043, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE00, 16'h0000, 0, 8'h00, 0, 1, 16'h8000, 0, 0, 8'h00, 1));
        // display handshake
        tbl.push_back(mk(0, 1, 16'hFE06, 16'h0058, 0, 8'h00, 0, 1, 16'h0000, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 8'h58, 1));
        tbl.push_back(mk(0, 1, 16'hFE06, 16'h0059, 0, 8'h00, 0, 1, 16'h0058, 0, 1, 8'h58, 1));
        tbl.push_back(mk(0, 0, 16'hFE06, 16'h0000, 0, 8'h00, 1, 1, 16'h0058, 0, 1, 8'h58, 1));
        tbl.push_back(mk(0, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 1, 16'h8000, 0, 0, 8'h58, 1));
        tbl.push_back(mk(0, 1, 16'hFE06, 16'h0060, 0, 8'h00, 0, 1, 16'h0058, 0, 0, 8'h58, 1));
        tbl.push_back(mk(0, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 8'h60, 1));
        // reset with a transfer pending; RAM survives
        tbl.push_back(mk(1, 0, 16'h0010, 16'h0000, 0, 8'h00, 0, 1, 16'h1234, 0, 1, 8'h60, 1));
        tbl.push_back(mk(0, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 1, 16'h8000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'h0010, 16'h0000, 0, 8'h00, 0, 1, 16'h1234, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        // writes to read-only status/data registers are ignored
        tbl.push_back(mk(0, 1, 16'hFE04, 16'h0000, 0, 8'h00, 0, 1, 16'h8000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE04, 16'h0000, 0, 8'h00, 0, 1, 16'h8000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 16'hFE02, 16'h00FF, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, 1));
        // machine control register
        tbl.push_back(mk(0, 1, 16'hFFFE, 16'h0000, 0, 8'h00, 0, 1, McrEn ? 16'h8000 : 16'h0000,
                         1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 16'hFFFE, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, !McrEn));
        tbl.push_back(mk(1, 0, 16'hFFFE, 16'h0000, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 8'h00, !McrEn));
        tbl.push_back(mk(0, 0, 16'hFFFE, 16'h0000, 0, 8'h00, 0, 1, McrEn ? 16'h8000 : 16'h0000,
                         1, 0, 8'h00, 1));

        reset = 1'b1; writeEnable = 1'b0; address = 16'h0000; dataToMemory = 16'h0000;
        kbd_valid = 1'b0; kbd_char = 8'h00; disp_ready = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) step(tbl[i], i);

        // Display sink always ready: DSR must come back exactly two cycles after the DDR write.
        step(mk(0, 1, 16'hFE06, 16'h0077, 0, 8'h00, 1, 1, 16'h0000, 1, 0, 8'h00, 1), 100);
        step(mk(0, 0, 16'hFE04, 16'h0000, 0, 8'h00, 1, 1, 16'h0000, 1, 1, 8'h77, 1), 101);
        n = 1;
        while (dataFromMemory !== 16'h8000 && n < 6) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("dsr_latency", 16'(n), 16'd2);

        // Back-to-back keys: second one only lands after the first is consumed.
        step(mk(0, 0, 16'h0010, 16'h0000, 1, 8'h61, 0, 1, 16'h1234, 1, 0, 8'h77, 1), 102);
        step(mk(0, 0, 16'hFE02, 16'h0000, 1, 8'h62, 0, 1, 16'h0061, 0, 0, 8'h77, 1), 103);
        step(mk(0, 0, 16'hFE02, 16'h0000, 1, 8'h62, 0, 1, 16'h0061, 1, 0, 8'h77, 1), 104);
        step(mk(0, 0, 16'hFE02, 16'h0000, 0, 8'h00, 0, 1, 16'h0062, 0, 0, 8'h77, 1), 105);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
